kbd_mmio: RTL

Memory-mapped responder that terminates the CPU data-memory load/store protocol (addr, datain, memop, we) for the keyboard device. It buffers scan codes from the keyboard front end in a FIFO and exposes DATA/STATUS/CTRL registers with the same byte-lane store alignment and load sign/zero extension that the data memory path applies. It sits on the data bus beside the data memory and is selected by the system address decoder through `cs`.

---
 rtl/kbd_mmio.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/kbd_mmio.sv
// Keyboard MMIO responder: scan-code FIFO behind DATA/STATUS/CTRL registers
// on the data-memory load/store bus, with lane-aligned stores and extended loads.
module kbd_mmio #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [7:0]  key_code,
  input  logic        cs,
  input  logic        re,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [2:0]  memop,
  input  logic [31:0] datain,
  output logic [31:0] dataout,
  output logic        irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic          r_en;
  logic          r_irqen;
  logic [31:0]   r_dout;
  logic          r_irq;

  logic          w_rd;
  logic          w_wr;
  logic [1:0]    w_reg;
  logic          w_empty;
  logic          w_full;
  logic [8:0]    w_cnt9;
  logic [31:0]   w_word;
  logic [3:0]    w_msk;
  logic [3:0]    w_be;
  logic [31:0]   w_wd;
  logic          w_pop;
  logic          w_flush;
  logic          w_try;
  logic          w_push;
  logic          w_ovf_set;
  logic          w_ovf_clr;
  logic [31:0]   w_sh;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_ld;

  assign w_rd    = cs & re;
  assign w_wr    = cs & we;
  assign w_reg   = addr[3:2];
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_cnt9  = 9'(r_count);

  always_comb begin
    w_word = '0;
    case (w_reg)
      2'd0: w_word = w_empty ? 32'd0 : {24'd0, r_mem[r_head]};
      2'd1: w_word = {16'd0, w_cnt9[7:0], 5'd0,
                      r_ovf, w_full, ~w_empty};
      2'd2: w_word = {30'd0, r_irqen, r_en};
      default: w_word = '0;
    endcase
  end

  always_comb begin
    w_msk = 4'b0000;
    case (memop[1:0])
      2'b00: w_msk = 4'b0001;
      2'b01: w_msk = 4'b0011;
      2'b10: w_msk = 4'b1111;
      default: w_msk = 4'b0000;
    endcase
  end

  assign w_be = w_msk << addr[1:0];
  assign w_wd = datain << {addr[1:0], 3'b000};

  assign w_flush   = w_wr & (w_reg == 2'd0) & (|w_be);
  assign w_pop     = w_rd & (w_reg == 2'd0) & ~w_empty;
  assign w_try     = key_valid & r_en;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign w_push    = w_try & (~w_full | w_pop) & ~w_flush;
  assign w_ovf_set = w_try & w_full & ~w_pop & ~w_flush;
  assign w_ovf_clr = w_wr & (w_reg == 2'd1) & w_be[0] & w_wd[2];

  assign w_sh   = w_word >> {addr[1:0], 3'b000};
  assign w_byte = w_sh[7:0];
  assign w_half = addr[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_ld = '0;
    case (memop)
      3'b000: w_ld = {{24{w_byte[7]}}, w_byte};
      3'b100: w_ld = {24'd0, w_byte};
      3'b001: w_ld = {{16{w_half[15]}}, w_half};
      3'b101: w_ld = {16'd0, w_half};
      3'b010: w_ld = w_word;
      default: w_ld = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= key_code;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_en    <= 1'b1;
      r_irqen <= 1'b0;
      r_dout  <= '0;
      r_irq   <= 1'b0;
    end else begin
      if (w_flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) r_tail <= r_tail + AW'(1);
        if (w_pop)  r_head <= r_head + AW'(1);
        if (w_push && !w_pop)      r_count <= r_count + CW'(1);
        else if (w_pop && !w_push) r_count <= r_count - CW'(1);
      end
      if (w_wr && (w_reg == 2'd2) && w_be[0]) begin
        r_en    <= w_wd[0];
        r_irqen <= w_wd[1];
      end
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
      r_irq <= r_irqen & ~w_empty;
      if (w_rd) r_dout <= w_ld;
    end
  end

  assign dataout = r_dout;
  assign irq     = r_irq;

endmodule
